// File: rtl/ram_bist.sv
// March C- self-test controller for a single-port async-read RAM.
// Ports: clk/rst, start -> busy/done/fail + fail_elem/addr/syn; ram_* drive the RAM.
module ram_bist #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [2:0]    fail_elem,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_syn,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [AW-1:0] ATOP = '1;
  localparam logic [DW-1:0] ONES = '1;

  state_t        state_q, state_d;
  logic [2:0]    elem_q, elem_d;
  logic [AW-1:0] addr_q, addr_d;

  logic          run;
  logic          down;
  logic          nxt_down;
  logic          last;
  logic [DW-1:0] expv;
  logic [DW-1:0] wpat;
  logic          mism;
  logic          cap;
  logic          clr;

  assign run = (state_q == RUN);

  // Elements 3 and 4 walk the array top-down.
  assign down     = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign nxt_down = (elem_q == 3'd2) || (elem_q == 3'd3);
  assign last     = down ? (addr_q == '0) : (addr_q == ATOP);

  always_comb begin
    expv = '0;
    wpat = '0;
    unique case (1'b1)
      (elem_q == 3'd1): wpat = ONES;
      (elem_q == 3'd2): expv = ONES;
      (elem_q == 3'd3): wpat = ONES;
      (elem_q == 3'd4): expv = ONES;
      default: ;
    endcase
  end

  // Element 0 only initialises; it is never checked.
  assign mism = run && (elem_q != 3'd0) &&
                (ram_dout != expv);

  assign busy     = run;
  assign done     = (state_q == DONE);
  assign ram_we   = run && (elem_q <= 3'd4);
  assign ram_addr = run ? addr_q : '0;
  assign ram_din  = ram_we ? wpat : '0;

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    cap     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          elem_d  = '0;
          addr_d  = '0;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (mism) begin
          state_d = DONE;
          cap     = 1'b1;
        end else if (last) begin
          if (elem_q == 3'd5) begin
            state_d = DONE;
          end else begin
            elem_d = elem_q + 3'd1;
            addr_d = nxt_down ? ATOP : '0;
          end
        end else begin
          addr_d = down ? addr_q - 1'b1
                        : addr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      elem_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fail      <= 1'b0;
      fail_elem <= '0;
      fail_addr <= '0;
      fail_syn  <= '0;
    end else if (cap) begin
      fail      <= 1'b1;
      fail_elem <= elem_q;
      fail_addr <= addr_q;
      fail_syn  <= ram_dout ^ expv;
    end
  end

endmodule
